// File: rtl/mlp_layer_sched.sv
// Control sequencer for the MLP datapath: weight/input load, layer-by-layer MAC with ping-pong activation banks, result streaming.
// Optional cycle counter output perf_cycles_o is enabled by defining MLP_SCHED_PERF_EN.
module mlp_layer_sched #(
  parameter int DIM        = 16,
  parameter int NUM_LAYERS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_valid_i,
  output logic        init_ready_o,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        w_ren_o,
  output logic        w_wen_o,
  output logic [10:0] w_addr_o,
  output logic        x_ren_o,
  output logic        x_wen_o,
  output logic        x_sel_o,
  output logic [7:0]  x_addr_o,
  output logic        partial_sum_store_o,
  output logic        x_sram_write_back_o
`ifdef MLP_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles_o
`endif
);

  localparam int W_WORDS = NUM_LAYERS * DIM * DIM;
  localparam logic [8:0]  LAST_IDX   = 9'(DIM - 1);
  localparam logic [11:0] W_LAST     = 12'(W_WORDS - 1);
  localparam logic [10:0] LAYER_LAST = 11'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_X, MAC_RD, MAC_DRAIN, WB, OUT_RD, OUT_LAST
  } state_e;

  state_e      state_q, state_d;
  logic        loaded_q, loaded_d;
  logic        src_q, src_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [8:0]  k_q, k_d;
  logic [8:0]  j_q, j_d;
  logic [10:0] layer_q, layer_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      src_q    <= 1'b0;
      wcnt_q   <= '0;
      k_q      <= '0;
      j_q      <= '0;
      layer_q  <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      src_q    <= src_d;
      wcnt_q   <= wcnt_d;
      k_q      <= k_d;
      j_q      <= j_d;
      layer_q  <= layer_d;
    end
  end

  // wcnt doubles as the load address and the run-time weight address, since
  // MAC reads walk the weight SRAM in strictly ascending order; k doubles as
  // the input-load word counter.
  always_comb begin
    state_d             = state_q;
    loaded_d            = loaded_q;
    src_d               = src_q;
    wcnt_d              = wcnt_q;
    k_d                 = k_q;
    j_d                 = j_q;
    layer_d             = layer_q;
    init_ready_o        = (state_q == IDLE) || (state_q == LOAD_W) || (state_q == LOAD_X);
    start_ready_o       = (state_q == IDLE) && loaded_q && !init_valid_i;
    busy_o              = (state_q != IDLE);
    result_valid_o      = 1'b0;
    w_ren_o             = 1'b0;
    w_wen_o             = 1'b0;
    w_addr_o            = '0;
    x_ren_o             = 1'b0;
    x_wen_o             = 1'b0;
    x_sel_o             = 1'b0;
    x_addr_o            = '0;
    partial_sum_store_o = 1'b0;
    x_sram_write_back_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_valid_i) begin
          w_wen_o  = 1'b1;
          wcnt_d   = 12'd1;
          loaded_d = 1'b0;
          state_d  = LOAD_W;
        end else if (start_valid_i && loaded_q) begin
          wcnt_d  = '0;
          k_d     = '0;
          j_d     = '0;
          layer_d = '0;
          src_d   = 1'b0;
          state_d = MAC_RD;
        end
      end
      LOAD_W: begin
        if (init_valid_i) begin
          w_wen_o  = 1'b1;
          w_addr_o = wcnt_q[10:0];
          wcnt_d   = wcnt_q + 12'd1;
          if (wcnt_q == W_LAST) begin
            k_d     = '0;
            state_d = LOAD_X;
          end
        end
      end
      LOAD_X: begin
        if (init_valid_i) begin
          x_wen_o  = 1'b1;
          x_addr_o = k_q[7:0];
          k_d      = k_q + 9'd1;
          if (k_q == LAST_IDX) begin
            k_d      = '0;
            loaded_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      // The MAC sees each product one cycle after its read, so the store
      // strobe lags the read by one cycle and spills into MAC_DRAIN.
      MAC_RD: begin
        w_ren_o             = 1'b1;
        w_addr_o            = wcnt_q[10:0];
        x_ren_o             = 1'b1;
        x_sel_o             = src_q;
        x_addr_o            = k_q[7:0];
        partial_sum_store_o = (k_q != '0);
        wcnt_d              = wcnt_q + 12'd1;
        k_d                 = k_q + 9'd1;
        if (k_q == LAST_IDX) begin
          k_d     = '0;
          state_d = MAC_DRAIN;
        end
      end
      MAC_DRAIN: begin
        partial_sum_store_o = 1'b1;
        state_d             = WB;
      end
      WB: begin
        x_sram_write_back_o = 1'b1;
        x_wen_o             = 1'b1;
        x_sel_o             = !src_q;
        x_addr_o            = j_q[7:0];
        k_d                 = '0;
        if (j_q != LAST_IDX) begin
          j_d     = j_q + 9'd1;
          state_d = MAC_RD;
        end else begin
          j_d     = '0;
          src_d   = !src_q;
          layer_d = layer_q + 11'd1;
          state_d = (layer_q == LAYER_LAST) ? OUT_RD : MAC_RD;
        end
      end
      OUT_RD: begin
        x_ren_o        = 1'b1;
        x_sel_o        = src_q;
        x_addr_o       = k_q[7:0];
        result_valid_o = (k_q != '0);
        k_d            = k_q + 9'd1;
        if (k_q == LAST_IDX) begin
          k_d     = '0;
          state_d = OUT_LAST;
        end
      end
      OUT_LAST: begin
        result_valid_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MLP_SCHED_PERF_EN
  logic        start_fire;
  logic [31:0] perf_q;

  assign start_fire = (state_q == IDLE) && loaded_q && start_valid_i && !init_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (start_fire) begin
      perf_q <= '0;
    end else if (((state_q == MAC_RD) || (state_q == MAC_DRAIN) || (state_q == WB))
                 && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_mlp_layer_sched.sv
// Directed bench for mlp_layer_sched at default parameters: reset, load, full run timing, init/start priority, mid-run reset.
module tb_mlp_layer_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        init_valid_i, start_valid_i;
  logic        init_ready_o, start_ready_o, result_valid_o, busy_o;
  logic        w_ren_o, w_wen_o, x_ren_o, x_wen_o, x_sel_o;
  logic [10:0] w_addr_o;
  logic [7:0]  x_addr_o;
  logic        partial_sum_store_o, x_sram_write_back_o;
`ifdef MLP_SCHED_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  mlp_layer_sched dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .init_valid_i        (init_valid_i),
    .init_ready_o        (init_ready_o),
    .start_valid_i       (start_valid_i),
    .start_ready_o       (start_ready_o),
    .result_valid_o      (result_valid_o),
    .busy_o              (busy_o),
    .w_ren_o             (w_ren_o),
    .w_wen_o             (w_wen_o),
    .w_addr_o            (w_addr_o),
    .x_ren_o             (x_ren_o),
    .x_wen_o             (x_wen_o),
    .x_sel_o             (x_sel_o),
    .x_addr_o            (x_addr_o),
    .partial_sum_store_o (partial_sum_store_o),
    .x_sram_write_back_o (x_sram_write_back_o)
`ifdef MLP_SCHED_PERF_EN
    ,
    .perf_cycles_o       (perf_cycles_o)
`endif
  );

  // Drive inputs just after a rising edge, then wait until mid-cycle so the
  // combinational outputs for this cycle are settled when sampled.
  task automatic applyStimulus(input logic iv, input logic sv);
    @(posedge clk_i);
    #1;
    init_valid_i  = iv;
    start_valid_i = sv;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Weight load from first_addr up to the last word (optionally with an idle
  // cycle after every 4 words), then the 16 input words into bank 0.
  task automatic loadSequence(input int first_addr, input bit gaps);
    int sent = 0, run = 0, pulses = 0, addr_err = 0, xgood = 0, cyc = 0;
    logic iv;
    while (sent < 2048 - first_addr && cyc < 4000) begin
      iv = !(gaps && run == 4);
      applyStimulus(iv, 1'b0);
      if (w_wen_o) begin
        if (int'(w_addr_o) != first_addr + pulses || !iv || w_ren_o) addr_err++;
        pulses++;
      end
      if (iv) begin
        sent++;
        run++;
      end else begin
        run = 0;
      end
      cyc++;
    end
    checkOutput("w_wen_pulses", pulses, 2048 - first_addr);
    checkOutput("w_addr_contiguous", addr_err, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (x_wen_o && !x_sel_o && int'(x_addr_o) == i && !w_wen_o && !x_ren_o) xgood++;
    end
    checkOutput("x_load_writes", xgood, 16);
    applyStimulus(1'b0, 1'b0);
    checkOutput("start_ready_after_load", start_ready_o, 1);
    checkOutput("busy_after_load", busy_o, 0);
  endtask

  int n, first_valid, last_valid, vcount, wren_count, wb_count, conflicts, out_sel_err;

  initial begin
    rst_ni        = 1'b0;
    init_valid_i  = 1'b0;
    start_valid_i = 1'b0;
    #12;
    checkOutput("rst_init_ready", init_ready_o, 1);
    checkOutput("rst_start_ready", start_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_enables", {w_ren_o, w_wen_o, x_ren_o, x_wen_o, result_valid_o,
                                partial_sum_store_o, x_sram_write_back_o}, 0);
    rst_ni = 1'b1;

    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_unloaded_start_ready", start_ready_o, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_unloaded_start_ignored", busy_o, 0);

    loadSequence(0, 1'b1);

    applyStimulus(1'b0, 1'b1);
    checkOutput("start_accept", start_ready_o, 1);
    first_valid = 0; last_valid = 0; vcount = 0; wren_count = 0;
    wb_count = 0; conflicts = 0; out_sel_err = 0;
    for (n = 1; n <= 3000; n++) begin
      applyStimulus(1'b0, 1'b0);
      if ((w_ren_o && w_wen_o) || (x_ren_o && x_wen_o)) conflicts++;
      if (w_ren_o) wren_count++;
      if (x_sram_write_back_o) wb_count++;
      if (result_valid_o) begin
        if (first_valid == 0) first_valid = n;
        last_valid = n;
        vcount++;
      end
      if (x_ren_o && !w_ren_o && x_sel_o) out_sel_err++;
      if (n == 1) begin
        checkOutput("mac_first_w", {w_ren_o, x_ren_o, w_addr_o}, {2'b11, 11'd0});
        checkOutput("mac_first_store", partial_sum_store_o, 0);
      end
      if (n == 2) checkOutput("mac_second", {partial_sum_store_o, w_addr_o, x_addr_o}, {1'b1, 11'd1, 8'd1});
      if (n == 17) checkOutput("mac_drain", {partial_sum_store_o, w_ren_o, x_ren_o, x_wen_o}, 4'b1000);
      if (n == 18) checkOutput("wb_first", {x_sram_write_back_o, x_wen_o, x_sel_o, x_addr_o}, {3'b111, 8'd0});
      if (n == 36) checkOutput("wb_second", {x_sram_write_back_o, x_sel_o, x_addr_o}, {2'b11, 8'd1});
      if (n == 289) checkOutput("layer1_first_read", {x_sel_o, w_addr_o, x_addr_o}, {1'b1, 11'd256, 8'd0});
      if (n == 306) checkOutput("layer1_wb", {x_sram_write_back_o, x_sel_o, x_addr_o}, {2'b10, 8'd0});
      if (first_valid != 0 && !result_valid_o) break;
    end
    checkOutput("first_result_latency", first_valid, 2306);
    checkOutput("result_count", vcount, 16);
    checkOutput("result_contiguous", last_valid - first_valid + 1, 16);
    checkOutput("w_ren_count", wren_count, 2048);
    checkOutput("wb_count", wb_count, 128);
    checkOutput("rw_conflicts", conflicts, 0);
    checkOutput("out_bank_sel", out_sel_err, 0);
    checkOutput("idle_after_run", busy_o, 0);
`ifdef MLP_SCHED_PERF_EN
    checkOutput("perf_cycles", perf_cycles_o, 2304);
`endif
    checkOutput("rerun_ready", start_ready_o, 1);

    applyStimulus(1'b1, 1'b1);
    checkOutput("tie_start_ready", start_ready_o, 0);
    checkOutput("tie_init_write", {init_ready_o, w_wen_o, w_addr_o}, {2'b11, 11'd0});
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_load_busy", {busy_o, start_ready_o, w_wen_o}, 3'b100);

    loadSequence(1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("pre_reset_mac", {busy_o, w_ren_o, x_ren_o}, 3'b111);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrun_reset_enables", {w_ren_o, w_wen_o, x_ren_o, x_wen_o, result_valid_o,
                                         partial_sum_store_o, x_sram_write_back_o}, 0);
    checkOutput("midrun_reset_busy", busy_o, 0);
    checkOutput("midrun_reset_ready", {init_ready_o, start_ready_o}, 2'b10);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_reset_start_ready", start_ready_o, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_start_ignored", {busy_o, w_ren_o}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
